// File: rtl/accum_phy_bank_if.sv
// Accumulator memory command/data interface: merged write port A and read port B.
// The master drives commands; the slave (accum_phy_bank) returns ready and read data.
interface accum_phy_bank_if #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned ZONE_WIDTH = 2
);
    localparam int unsigned BUS_W = NUM_BANKS * DATA_WIDTH;

    logic                  wr_valid;
    logic                  wr_ready;
    logic                  accum_en;
    logic [NUM_BANKS-1:0]  wr_mask;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ZONE_WIDTH-1:0] wr_zone_id;
    logic [BUS_W-1:0]      wdata;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [NUM_BANKS-1:0]  rd_mask;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ZONE_WIDTH-1:0] rd_zone_id;
    logic                  rvalid;
    logic [BUS_W-1:0]      rdata;

    modport master (
        output wr_valid, accum_en, wr_mask, wr_addr, wr_zone_id, wdata,
        output rd_valid, rd_mask, rd_addr, rd_zone_id,
        input  wr_ready, rd_ready, rvalid, rdata
    );

    modport slave (
        input  wr_valid, accum_en, wr_mask, wr_addr, wr_zone_id, wdata,
        input  rd_valid, rd_mask, rd_addr, rd_zone_id,
        output wr_ready, rd_ready, rvalid, rdata
    );
endinterface

// File: rtl/accum_phy_bank.sv
// Banked accumulator memory with overwrite/accumulate writes, S2 forwarding and read bypass.
// Optional macro ACCUM_LANE16_EN splits the accumulate add into independent 16-bit lanes.
module accum_phy_bank #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned ZONE_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rstn,
    accum_phy_bank_if.slave    bus
);
    localparam int unsigned FULL_AW = ZONE_WIDTH + ADDR_WIDTH;
    localparam int unsigned DEPTH   = 1 << FULL_AW;
    localparam int unsigned BUS_W   = NUM_BANKS * DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;

`ifdef ACCUM_LANE16_EN
    if ((DATA_WIDTH % 16) != 0) begin : g_lane_chk
        $error("accum_phy_bank: DATA_WIDTH must be a multiple of 16 with ACCUM_LANE16_EN");
    end
`endif

    // Accumulate adder; wraps per bank, or per 16-bit lane when lanes are enabled.
    function automatic word_t acc_add(input word_t a, input word_t b);
`ifdef ACCUM_LANE16_EN
        word_t s;
        s = '0;
        for (int unsigned l = 0; l < DATA_WIDTH / 16; l++) begin
            s[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
        end
        return s;
`else
        return a + b;
`endif
    endfunction

    word_t mem [NUM_BANKS][DEPTH];

    logic                 s2_valid;
    logic                 s2_accum;
    logic [NUM_BANKS-1:0] s2_mask;
    logic [FULL_AW-1:0]   s2_addr;
    logic [BUS_W-1:0]     s2_wdata;
    word_t                rmw_old [NUM_BANKS];

    logic                 rmw_c;
    logic                 rd_fire_c;
    logic [FULL_AW-1:0]   wr_full_c;
    logic [FULL_AW-1:0]   pb_addr_c;
    word_t                s2_result_c [NUM_BANKS];
    word_t                pb_val_c    [NUM_BANKS];

    // Port B belongs to the RMW read whenever an accumulate is accepted.
    assign rmw_c         = bus.wr_valid && bus.accum_en;
    assign bus.wr_ready  = 1'b1;
    assign bus.rd_ready  = !rmw_c;
    assign rd_fire_c     = bus.rd_valid && !rmw_c;
    assign wr_full_c     = {bus.wr_zone_id, bus.wr_addr};
    assign pb_addr_c     = rmw_c ? wr_full_c : {bus.rd_zone_id, bus.rd_addr};

    // S2 result, and port-B value with the uncommitted S2 write forwarded per bank.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            s2_result_c[b] = s2_accum ? acc_add(rmw_old[b], s2_wdata[b*DATA_WIDTH +: DATA_WIDTH])
                                      : s2_wdata[b*DATA_WIDTH +: DATA_WIDTH];
            pb_val_c[b]    = (s2_valid && s2_mask[b] && (s2_addr == pb_addr_c))
                             ? s2_result_c[b] : mem[b][pb_addr_c];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid   <= 1'b0;
            s2_accum   <= 1'b0;
            s2_mask    <= '0;
            s2_addr    <= '0;
            s2_wdata   <= '0;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                rmw_old[b] <= '0;
            end
        end else begin
            s2_valid   <= bus.wr_valid;
            bus.rvalid <= rd_fire_c;
            if (bus.wr_valid) begin
                s2_accum <= bus.accum_en;
                s2_mask  <= bus.wr_mask;
                s2_addr  <= wr_full_c;
                s2_wdata <= bus.wdata;
            end
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (rmw_c) begin
                    rmw_old[b] <= pb_val_c[b];
                end
                if (rd_fire_c) begin
                    bus.rdata[b*DATA_WIDTH +: DATA_WIDTH] <= bus.rd_mask[b] ? pb_val_c[b] : '0;
                end
            end
        end
    end

    // Memory array is not reset; reset clears s2_valid asynchronously, dropping the staged write.
    always_ff @(posedge clk) begin
        if (s2_valid) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (s2_mask[b]) begin
                    mem[b][s2_addr] <= s2_result_c[b];
                end
            end
        end
    end
endmodule

// File: tb/tb_accum_phy_bank.sv
// Scoreboard bench for accum_phy_bank: directed vectors push expected read data,
// a negedge monitor pops and compares on every rvalid.
module tb_accum_phy_bank;
    localparam int unsigned NB = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = NB * DW;

    logic clk;
    logic rstn;
    int   n_pass;
    int   n_total;
    logic [BW-1:0] exp_q [$];

    accum_phy_bank_if bus ();

    accum_phy_bank dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] pk(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                         input logic [DW-1:0] b2, input logic [DW-1:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0; bus.accum_en = 1'b0; bus.wr_mask = '0; bus.wr_addr = '0;
        bus.wr_zone_id = '0; bus.wdata = '0;
        bus.rd_valid = 1'b0; bus.rd_mask = '0; bus.rd_addr = '0; bus.rd_zone_id = '0;
    endtask

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input logic wv, input logic acc, input logic [3:0] wm,
                         input logic [8:0] wa, input logic [1:0] wz, input logic [BW-1:0] wd,
                         input logic rv, input logic [3:0] rm, input logic [8:0] ra,
                         input logic [1:0] rz, input logic [BW-1:0] exp_rd);
        logic exp_ready;
        bus.wr_valid = wv; bus.accum_en = acc; bus.wr_mask = wm; bus.wr_addr = wa;
        bus.wr_zone_id = wz; bus.wdata = wd;
        bus.rd_valid = rv; bus.rd_mask = rm; bus.rd_addr = ra; bus.rd_zone_id = rz;
        exp_ready = !(wv && acc);
        #1;
        check("rd_ready", BW'(bus.rd_ready), BW'(exp_ready));
        check("wr_ready", BW'(bus.wr_ready), BW'(1'b1));
        if (rv && exp_ready) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wr(input logic acc, input logic [3:0] wm, input logic [8:0] wa,
                      input logic [1:0] wz, input logic [BW-1:0] wd);
        drive(1'b1, acc, wm, wa, wz, wd, 1'b0, 4'h0, 9'd0, 2'd0, '0);
    endtask

    task automatic rd(input logic [3:0] rm, input logic [8:0] ra, input logic [1:0] rz,
                      input logic [BW-1:0] exp_rd);
        drive(1'b0, 1'b0, 4'h0, 9'd0, 2'd0, '0, 1'b1, rm, ra, rz, exp_rd);
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 4'h0, 9'd0, 2'd0, '0, 1'b0, 4'h0, 9'd0, 2'd0, '0);
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn && bus.rvalid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response", bus.rdata);
            end else begin
                check("rdata", bus.rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] e_wrap;
        logic [DW-1:0] e_lane;
        n_pass = 0;
        n_total = 0;
        idle_inputs();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid", BW'(bus.rvalid), '0);
        check("reset_rdata", bus.rdata, '0);
        check("reset_rd_ready", BW'(bus.rd_ready), BW'(1'b1));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Plain write then reads: bypass at T+1, memory at T+2.
        wr(1'b0, 4'hF, 9'd5, 2'd0, pk(1, 2, 3, 4));
        rd(4'hF, 9'd5, 2'd0, pk(1, 2, 3, 4));
        rd(4'hF, 9'd5, 2'd0, pk(1, 2, 3, 4));

        // Back-to-back accumulates through S2 forwarding: 10+5+5+5.
        wr(1'b0, 4'h1, 9'd7, 2'd0, pk(10, 0, 0, 0));
        wr(1'b1, 4'h1, 9'd7, 2'd0, pk(5, 0, 0, 0));
        wr(1'b1, 4'h1, 9'd7, 2'd0, pk(5, 0, 0, 0));
        wr(1'b1, 4'h1, 9'd7, 2'd0, pk(5, 0, 0, 0));
        rd(4'h1, 9'd7, 2'd0, pk(25, 0, 0, 0));

        // Read during accumulate is ignored; read with a plain write is accepted.
        drive(1'b1, 1'b1, 4'h1, 9'd7, 2'd0, pk(1, 0, 0, 0), 1'b1, 4'h1, 9'd7, 2'd0, '0);
        drive(1'b1, 1'b0, 4'h1, 9'd9, 2'd0, pk(99, 0, 0, 0), 1'b1, 4'h1, 9'd7, 2'd0, pk(26, 0, 0, 0));
        rd(4'h1, 9'd9, 2'd0, pk(99, 0, 0, 0));

        // Write and read masks.
        wr(1'b0, 4'hF, 9'd3, 2'd1, pk(100, 101, 102, 103));
        wr(1'b0, 4'b0101, 9'd3, 2'd1, pk(200, 201, 202, 203));
        nop();
        rd(4'b0011, 9'd3, 2'd1, pk(200, 101, 0, 0));
        // Same-cycle plain write and read returns the old value.
        drive(1'b1, 1'b0, 4'hF, 9'd3, 2'd1, pk(7, 7, 7, 7), 1'b1, 4'hF, 9'd3, 2'd1, pk(200, 101, 202, 103));
        drive(1'b1, 1'b0, 4'h0, 9'd3, 2'd1, pk(9, 9, 9, 9), 1'b1, 4'hF, 9'd3, 2'd1, pk(7, 7, 7, 7));
        rd(4'h0, 9'd3, 2'd1, '0);
        rd(4'hF, 9'd3, 2'd1, pk(7, 7, 7, 7));

        // Wrap behaviour of the accumulate adder.
`ifdef ACCUM_LANE16_EN
        e_wrap = 64'hFFFF_FFFF_FFFF_0001;
        e_lane = 64'h0000_0000_0000_0001;
`else
        e_wrap = 64'h0000_0000_0000_0001;
        e_lane = 64'h0000_0000_0001_0001;
`endif
        wr(1'b0, 4'h1, 9'd11, 2'd2, pk({DW{1'b1}}, 0, 0, 0));
        wr(1'b1, 4'h1, 9'd11, 2'd2, pk(2, 0, 0, 0));
        wr(1'b0, 4'h1, 9'd12, 2'd2, pk(64'hFFFF, 0, 0, 0));
        wr(1'b1, 4'h1, 9'd12, 2'd2, pk(2, 0, 0, 0));
        rd(4'h1, 9'd11, 2'd2, pk(e_wrap, 0, 0, 0));
        rd(4'h1, 9'd12, 2'd2, pk(e_lane, 0, 0, 0));

        // Per-bank forwarding: bank0 from S2, bank1 from memory.
        wr(1'b0, 4'hF, 9'd20, 2'd0, pk(1, 2, 3, 4));
        nop();
        wr(1'b0, 4'h1, 9'd20, 2'd0, pk(10, 0, 0, 0));
        wr(1'b1, 4'b0011, 9'd20, 2'd0, pk(1, 1, 0, 0));
        rd(4'hF, 9'd20, 2'd0, pk(11, 3, 3, 4));

        // Reset while an accumulate sits in S2 drops it and the in-flight read.
        wr(1'b0, 4'h1, 9'd13, 2'd3, pk(50, 0, 0, 0));
        nop();
        nop();
        wr(1'b1, 4'h1, 9'd13, 2'd3, pk(7, 0, 0, 0));
        bus.rd_valid = 1'b1; bus.rd_mask = 4'h1; bus.rd_addr = 9'd13; bus.rd_zone_id = 2'd3;
        #2 rstn = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_rvalid", BW'(bus.rvalid), '0);
        check("midreset_rdata", bus.rdata, '0);
        idle_inputs();
        @(posedge clk);
        #1;
        check("held_reset_rvalid", BW'(bus.rvalid), '0);
        rstn = 1'b1;
        nop();
        rd(4'h1, 9'd13, 2'd3, pk(50, 0, 0, 0));

        nop();
        nop();
        nop();
        check("pending_reads", BW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
